// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage.
// The instruction-queue entry layout lives here so the stage and any
// future checker bind agree on field order.
package wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int FLAGS_W    = 4;
  localparam int DATA_W     = 64;

  // One completed instruction waiting to retire.
  typedef struct packed {
    logic [DATA_W-1:0]     result;
    logic [REG_ADDR_W-1:0] write_addr;
    logic                  regwrite;
    logic                  memtoreg;
    logic                  setflags;
    logic [FLAGS_W-1:0]    flags;
  } wb_entry_t;

endpackage

// File: rtl/writeback_stage_sync_fifo.sv
// Module sync_fifo: single-clock FIFO with asynchronous active-low reset.
// Pointers carry one extra wrap bit beyond log2(DEPTH) index bits so that
// full and empty are distinguishable. A push while full and a pop while
// empty are ignored; a simultaneous push and pop keeps occupancy unchanged.
// Read data is the current head, visible combinationally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;
  assign rdata = mem[rd_ptr[AW-1:0]];

  // Pointer advance; reset empties the queue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset because the pointers gate reads.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: final pipeline stage. Queues completed instructions,
// merges in-order load data from the data memory, and retires at most one
// instruction per cycle in program order onto the writeback_* bus.
//
// Optional build macro WB_RETIRE_COUNT_EN adds a 64-bit retire_count output
// that counts every retiring edge (including regwrite=0 retires).
//
// Handshake: an instruction transfers on a rising clk edge where
// in_valid && in_ready are both high. in_ready is !IQ_full from registered
// pointers only; a retire in the same cycle does not raise it. The load
// response channel (mem_rsp_valid) has no ready; every beat is either
// queued or dropped with rsp_error set.
module writeback_stage
  import wb_pkg::wb_entry_t;
  import wb_pkg::REG_ADDR_W;
  import wb_pkg::FLAGS_W;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = wb_pkg::DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_result,
  input  logic [REG_ADDR_W-1:0] in_write_addr,
  input  logic                  in_regwrite,
  input  logic                  in_memtoreg,
  input  logic                  in_setflags,
  input  logic [FLAGS_W-1:0]    in_flags,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_W-1:0]     mem_rsp_data,
  output logic [REG_ADDR_W-1:0] writeback_writeaddr,
  output logic [DATA_W-1:0]     writeback_writedata,
  output logic                  writeback_regwrite,
  output logic                  writeback_setflags,
  output logic [FLAGS_W-1:0]    writeback_flags,
`ifdef WB_RETIRE_COUNT_EN
  output logic [63:0]           retire_count,
`endif
  output logic                  rsp_error
);

  localparam int AW = $clog2(DEPTH);

  wb_entry_t         in_entry;
  wb_entry_t         iq_head;
  logic              iq_push;
  logic              iq_full;
  logic              iq_empty;
  logic [AW:0]       iq_count;

  logic [DATA_W-1:0] rq_head;
  logic              rq_push;
  logic              rq_full;
  logic              rq_empty;
  logic [AW:0]       rq_count;

  logic [AW:0]       load_cnt;
  logic [AW:0]       outstanding;
  logic              retire;
  logic              rsp_drop;
  logic              unused_iq_count;

  // IQ occupancy is observable through full/empty; the count is not needed.
  assign unused_iq_count = ^iq_count;

  // Pack the incoming instruction into a queue entry.
  always_comb begin
    in_entry            = '0;
    in_entry.result     = in_result;
    in_entry.write_addr = in_write_addr;
    in_entry.regwrite   = in_regwrite;
    in_entry.memtoreg   = in_memtoreg;
    in_entry.setflags   = in_setflags;
    in_entry.flags      = in_flags;
  end

  assign in_ready = !iq_full;
  assign iq_push  = in_valid && !iq_full;

  // Loads queued in IQ that have not yet received their data beat.
  assign outstanding = load_cnt - rq_count;
  assign rq_push     = mem_rsp_valid && (outstanding != '0) && !rq_full;
  assign rsp_drop    = mem_rsp_valid && !rq_push;

  // A load head waits for its data; anything else retires as soon as present.
  assign retire = !iq_empty && (!iq_head.memtoreg || !rq_empty);

  sync_fifo #(
    .WIDTH ($bits(wb_entry_t)),
    .DEPTH (DEPTH)
  ) u_iq (
    .clk   (clk),
    .rst   (rst),
    .push  (iq_push),
    .wdata (in_entry),
    .pop   (retire),
    .rdata (iq_head),
    .full  (iq_full),
    .empty (iq_empty),
    .count (iq_count)
  );

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (DEPTH)
  ) u_rq (
    .clk   (clk),
    .rst   (rst),
    .push  (rq_push),
    .wdata (mem_rsp_data),
    .pop   (retire && iq_head.memtoreg),
    .rdata (rq_head),
    .full  (rq_full),
    .empty (rq_empty),
    .count (rq_count)
  );

  // Track how many loads sit in the IQ so orphan responses can be detected.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_cnt <= '0;
    end else begin
      case ({iq_push && in_memtoreg, retire && iq_head.memtoreg})
        2'b10:   load_cnt <= load_cnt + 1'b1;
        2'b01:   load_cnt <= load_cnt - 1'b1;
        default: load_cnt <= load_cnt;
      endcase
    end
  end

  // Writeback output register: strobes pulse for one cycle per retire,
  // address/data/flags hold their last retired values otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      writeback_writeaddr <= '0;
      writeback_writedata <= '0;
      writeback_regwrite  <= 1'b0;
      writeback_setflags  <= 1'b0;
      writeback_flags     <= '0;
    end else if (retire) begin
      writeback_writeaddr <= iq_head.write_addr;
      writeback_writedata <= iq_head.memtoreg ? rq_head : iq_head.result;
      writeback_regwrite  <= iq_head.regwrite;
      writeback_setflags  <= iq_head.setflags && !iq_head.memtoreg;
      writeback_flags     <= iq_head.flags;
    end else begin
      writeback_regwrite  <= 1'b0;
      writeback_setflags  <= 1'b0;
    end
  end

  // Sticky protocol error for dropped load responses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_error <= 1'b0;
    end else if (rsp_drop) begin
      rsp_error <= 1'b1;
    end
  end

`ifdef WB_RETIRE_COUNT_EN
  // Free-running retire counter, wraps naturally at 2^64.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retire_count <= '0;
    end else if (retire) begin
      retire_count <= retire_count + 64'd1;
    end
  end
`endif

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage. Accepts completed instructions from the memory stage and retires them strictly in program order.
- Merges in-order data-memory load responses with the ALU results they belong to.
- Drives the writeback_* bus, which the decode stage consumes for register-file writes and flag updates.
- Buffers up to DEPTH in-flight instructions so that load latency stalls only this stage's input, not the whole pipeline.

Parameters:
- DEPTH, 4, instruction-queue and load-response-queue entries; power of 2, minimum 2.
- DATA_W, 64, datapath width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  memory stage presents an instruction.
- in_ready  out  1  stage can accept; equals instruction queue not full.
- in_result  in  DATA_W  ALU result.
- in_write_addr  in  5  destination register.
- in_regwrite  in  1  instruction writes a register.
- in_memtoreg  in  1  instruction is a load; write data comes from memory.
- in_setflags  in  1  instruction updates flags.
- in_flags  in  4  ALU flags.
- mem_rsp_valid  in  1  load data beat, in load order; no backpressure.
- mem_rsp_data  in  DATA_W  load data.
- writeback_writeaddr  out  5  to decode register file.
- writeback_writedata  out  DATA_W  to decode register file.
- writeback_regwrite  out  1  one-cycle write strobe.
- writeback_setflags  out  1  one-cycle flag-update strobe.
- writeback_flags  out  4  flag value.
- rsp_error  out  1  sticky: load response with no outstanding load, or response queue overflow.

Behaviour:
- Reset (rst low, asynchronous): both queues empty; every output 0 except in_ready, which is 1.
- Outputs are registered. rsp_error clears only on reset.
- **Enqueue:** on a clk edge with in_valid && in_ready, push {result, write_addr, regwrite, memtoreg, setflags, flags} into the instruction queue (IQ).
- in_ready = !IQ_full. A push in the same cycle as a retire from a full IQ is not accepted; in_ready is not combinationally relaxed by a retire.
- **Load responses:** each mem_rsp_valid beat pushes mem_rsp_data into the response queue (RQ).
  - Loads outstanding = IQ loads − RQ count.
  - A beat arriving with zero outstanding loads is dropped and sets rsp_error.
  - A beat arriving with RQ full is dropped and sets rsp_error.
- **Retire decision** (combinational on the IQ head, at most one retire per cycle):
  - Non-load head: retires whenever IQ is non-empty.
  - Load head: retires only when RQ is non-empty; pops both IQ and RQ. Otherwise it stalls; younger entries wait.
- **Output register**, updated at the retiring edge:
  - writeback_writeaddr = head write_addr.
  - writeback_writedata = RQ head data for a load, head result otherwise.
  - writeback_regwrite = head regwrite.
  - writeback_setflags = head setflags && !memtoreg; loads never update flags.
  - writeback_flags = head flags.
- No-retire cycle: regwrite and setflags go to 0; addr, data and flags hold their last values.
- **Latency:**
  - ALU instruction accepted at edge t into an empty IQ: strobes high in the cycle after edge t+1.
  - Load: response sampled at edge r gives strobes after edge r+1, provided the load is the head.
  - Full throughput is one retire per cycle.
- Simultaneous push and pop on IQ or RQ is legal; occupancy is unchanged.
- Pointer wrap uses log2(DEPTH) index bits plus one extra bit to distinguish full from empty.
- write_addr 0 is passed through unmodified; register-0 policy belongs to the register file.
- Reset during operation discards all queued instructions and responses. The memory stage is reset concurrently.

Optional Feature:
- Macro: WB_RETIRE_COUNT_EN.
- Defined:
  - Adds output retire_count (64 bits), reset to 0.
  - Increments by 1 on every retiring edge, including retires with regwrite=0.
  - Wraps at 2^64.
- Undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Package wb_pkg holds:
  - constants REG_ADDR_W=5, FLAGS_W=4, DATA_W=64;
  - typedef struct packed wb_entry_t {result, write_addr, regwrite, memtoreg, setflags, flags}.
- Sub-module sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count), instantiated twice:
  - IQ with WIDTH = $bits(wb_entry_t);
  - RQ with WIDTH = DATA_W.

Test Plan:
- ALU op {result=0x1234, addr=7, regwrite=1, setflags=1, flags=4'b1010} accepted at edge t → in cycle after t+1: regwrite=1, writeaddr=7, writedata=0x1234, setflags=1, flags=1010; both strobes low the next cycle.
- Load to addr 3, then ALU op to addr 4; response 0xDEAD_BEEF sent 5 cycles later → no strobes until the response; addr 3/0xDEADBEEF retires at r+1, addr 4 at r+2; setflags stays 0 on the load even if in_setflags=1.
- Fill with DEPTH=4 loads and no responses → in_ready=0 after the 4th accept; a 5th in_valid is held. Send 4 responses back-to-back → 4 consecutive retires; in_ready returns to 1.
- mem_rsp_valid with the IQ empty → rsp_error=1 and stays 1; writeback strobes stay 0; only reset clears it.
- Assert rst low mid-stream with 3 entries queued → outputs 0 and in_ready=1 immediately (asynchronous); no retire after release.
- With WB_RETIRE_COUNT_EN, 10 mixed instructions including 2 with regwrite=0 → retire_count=10.
